// File: rtl/fma_dot_sched.sv
// Dot-product sequencer: feeds each (a, b) pair plus the running sum to one shared fma unit
// as three consecutive load beats and accumulates float_out until N products are summed.
module fma_dot_sched #(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1),
  parameter int unsigned TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [LEN_W-1:0] req_len,
  output logic             req_ready,
  input  logic             op_valid,
  input  logic [31:0]      op_a,
  input  logic [31:0]      op_b,
  output logic             op_ready,
  output logic             fma_start,
  output logic [31:0]      fma_float_in,
  output logic             fma_rst,
  input  logic             fma_ready,
  input  logic             fma_error,
  input  logic [31:0]      fma_float_out,
  output logic [31:0]      result,
  output logic             done,
  output logic             err,
  output logic             busy
);

  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StIssueA = 3'd2;
  localparam logic [2:0] StIssueB = 3'd3;
  localparam logic [2:0] StIssueC = 3'd4;
  localparam logic [2:0] StWait   = 3'd5;
  localparam logic [2:0] StDone   = 3'd6;
  localparam logic [2:0] StErr    = 3'd7;

  logic [2:0]       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [31:0]      acc_q, acc_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic             hold_q, hold_d;
  logic [31:0]      result_d;
  logic [31:0]      float_in_d;
  logic             op_take;

  assign cnt_inc = cnt_q + LEN_W'(1);

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    wdog_d   = wdog_q;
    hold_d   = 1'b0;
    result_d = result;
    op_take  = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_valid && req_ready) begin
          len_d = req_len;
          acc_d = '0;
          cnt_d = '0;
          if (req_len == '0) begin
            state_d  = StDone;
            result_d = '0;
          end else if (req_len > LEN_W'(MAX_LEN)) begin
            state_d = StErr;
          end else begin
            state_d = StFetch;
          end
        end
      end
      StFetch: begin
        if (op_valid) begin
          op_take = 1'b1;
          a_d     = op_a;
          b_d     = op_b;
          state_d = StIssueA;
        end
      end
      StIssueA: state_d = StIssueB;
      StIssueB: state_d = StIssueC;
      StIssueC: begin
        wdog_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        // fma_error outranks a coincident fma_ready
        if (fma_error) begin
          state_d = StErr;
        end else if (fma_ready) begin
          acc_d = fma_float_out;
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d  = StDone;
            result_d = fma_float_out;
          end else begin
            state_d = StFetch;
          end
        end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
          state_d = StErr;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      StDone: state_d = StIdle;
      StErr: begin
        // two cycles in ERR keep fma_rst asserted long enough to flush the fma
        acc_d = '0;
        if (hold_q) state_d = StIdle;
        else        hold_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    case (state_d)
      StIssueA: float_in_d = a_d;
      StIssueB: float_in_d = b_d;
      StIssueC: float_in_d = acc_d;
      default:  float_in_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      len_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      wdog_q  <= '0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      wdog_q  <= wdog_d;
      hold_q  <= hold_d;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_ready    <= 1'b0;
      op_ready     <= 1'b0;
      fma_start    <= 1'b0;
      fma_float_in <= '0;
      fma_rst      <= 1'b1;
      result       <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      busy         <= 1'b0;
    end else begin
      req_ready    <= (state_d == StIdle);
      op_ready     <= op_take;
      fma_start    <= (state_d == StIssueA);
      fma_float_in <= float_in_d;
      fma_rst      <= (state_d == StErr);
      result       <= result_d;
      done         <= (state_d == StDone);
      err          <= (state_d == StErr) && (state_q != StErr);
      busy         <= (state_d != StIdle);
    end
  end

endmodule

// File: tb/tb_fma_dot_sched.sv
// Directed bench for fma_dot_sched: the bench plays the fma unit and operand source, and
// checks issue beats, results, pulses and abort paths against hand-computed values.
module tb_fma_dot_sched;

  localparam int unsigned LEN_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req_valid = 1'b0;
  logic [LEN_W-1:0] req_len = '0;
  logic             req_ready;
  logic             op_valid = 1'b0;
  logic [31:0]      op_a = '0;
  logic [31:0]      op_b = '0;
  logic             op_ready;
  logic             fma_start;
  logic [31:0]      fma_float_in;
  logic             fma_rst;
  logic             fma_ready = 1'b0;
  logic             fma_error = 1'b0;
  logic [31:0]      fma_float_out = '0;
  logic [31:0]      result;
  logic             done;
  logic             err;
  logic             busy;

  int n_vec = 0;
  int n_bad = 0;
  int n_done = 0, n_err = 0, n_opr = 0, n_start = 0, n_frst = 0;

  fma_dot_sched #(
    .MAX_LEN(16),
    .LEN_W  (LEN_W),
    .TIMEOUT(32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_len      (req_len),
    .req_ready    (req_ready),
    .op_valid     (op_valid),
    .op_a         (op_a),
    .op_b         (op_b),
    .op_ready     (op_ready),
    .fma_start    (fma_start),
    .fma_float_in (fma_float_in),
    .fma_rst      (fma_rst),
    .fma_ready    (fma_ready),
    .fma_error    (fma_error),
    .fma_float_out(fma_float_out),
    .result       (result),
    .done         (done),
    .err          (err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done)      n_done++;
    if (err)       n_err++;
    if (op_ready)  n_opr++;
    if (fma_start) n_start++;
    if (fma_rst)   n_frst++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic start_job(input string tag, input logic [LEN_W-1:0] len);
    logic rdy;
    rdy = 1'b0;
    for (int i = 0; i < 40 && !rdy; i++) begin
      @(negedge clk);
      rdy = req_ready;
    end
    check({tag, "_req_ready"}, 32'(rdy), 32'd1);
    req_len   = len;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    logic rdy;
    rdy = 1'b0;
    for (int i = 0; i < 60 && !rdy; i++) begin
      @(negedge clk);
      rdy = req_ready;
    end
    check({tag, "_idle"}, 32'(rdy), 32'd1);
  endtask

  // mode 0: answer with resp; 1: never answer; 2: answer with fma_error and fma_ready together
  task automatic serve(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c_exp, input logic [31:0] resp, input int mode);
    logic seen;
    op_a     = a;
    op_b     = b;
    op_valid = 1'b1;
    seen     = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = fma_start;
    end
    check({tag, "_start"}, 32'(seen), 32'd1);
    if (!seen) return;
    check({tag, "_beat_a"}, fma_float_in, a);
    check({tag, "_op_ready"}, 32'(op_ready), 32'd1);
    @(negedge clk);
    check({tag, "_beat_b"}, fma_float_in, b);
    check({tag, "_start_low"}, 32'(fma_start), 32'd0);
    @(negedge clk);
    check({tag, "_beat_c"}, fma_float_in, c_exp);
    if (mode == 1) return;
    repeat (5) @(negedge clk);
    fma_float_out = resp;
    fma_ready     = 1'b1;
    fma_error     = (mode == 2);
    @(negedge clk);
    fma_ready = 1'b0;
    fma_error = 1'b0;
  endtask

  initial begin
    int s_done, s_err, s_opr, s_start, s_frst, n;
    logic seen;

    // reset values
    #12;
    check("rst_fma_rst", 32'(fma_rst), 32'd1);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_float_in", fma_float_in, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rel_fma_rst", 32'(fma_rst), 32'd0);
    check("rel_req_ready", 32'(req_ready), 32'd1);

    // N=1: 1.75 * 1.5 + 0 = 2.625
    s_done = n_done;
    start_job("n1", 5'd1);
    serve("n1e0", 32'h3FE00000, 32'h3FC00000, 32'h00000000, 32'h40280000, 0);
    check("n1_done", 32'(done), 32'd1);
    check("n1_result", result, 32'h40280000);
    op_valid = 1'b0;
    wait_idle("n1");
    check("n1_busy", 32'(busy), 32'd0);
    check("n1_done_cnt", 32'(n_done - s_done), 32'd1);

    // N=2 with op_valid held: 2.625 + 2.0 * 0.5 = 3.625
    s_opr = n_opr;
    start_job("n2", 5'd2);
    serve("n2e0", 32'h3FE00000, 32'h3FC00000, 32'h00000000, 32'h40280000, 0);
    serve("n2e1", 32'h40000000, 32'h3F000000, 32'h40280000, 32'h40680000, 0);
    check("n2_done", 32'(done), 32'd1);
    check("n2_result", result, 32'h40680000);
    op_valid = 1'b0;
    wait_idle("n2");
    check("n2_op_ready_cnt", 32'(n_opr - s_opr), 32'd2);

    // N=MAX_LEN+1 aborts without consuming operands
    op_a = 32'h3F800000; op_b = 32'h3F800000; op_valid = 1'b1;
    s_err = n_err; s_opr = n_opr; s_frst = n_frst; s_start = n_start;
    start_job("n17", 5'd17);
    wait_idle("n17");
    op_valid = 1'b0;
    check("n17_err_cnt", 32'(n_err - s_err), 32'd1);
    check("n17_fma_rst_cycles", 32'(n_frst - s_frst), 32'd2);
    check("n17_op_ready_cnt", 32'(n_opr - s_opr), 32'd0);
    check("n17_start_cnt", 32'(n_start - s_start), 32'd0);
    check("n17_result", result, 32'h40680000);

    // watchdog: fma never answers
    start_job("to", 5'd1);
    serve("toe0", 32'h3FE00000, 32'h3FC00000, 32'h00000000, 32'h0, 1);
    op_valid = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      seen = err;
    end
    check("to_err_latency", 32'(n), 32'd33);
    wait_idle("to");
    check("to_busy", 32'(busy), 32'd0);
    check("to_result_kept", result, 32'h40680000);

    // recovery job: 2.0 * 3.0 = 6.0
    start_job("rc", 5'd1);
    serve("rce0", 32'h40000000, 32'h40400000, 32'h00000000, 32'h40C00000, 0);
    check("rc_done", 32'(done), 32'd1);
    check("rc_result", result, 32'h40C00000);
    op_valid = 1'b0;
    wait_idle("rc");

    // fma_error and fma_ready together: error wins
    start_job("ee", 5'd1);
    serve("eee0", 32'h3FE00000, 32'h3FC00000, 32'h00000000, 32'h41000000, 2);
    op_valid = 1'b0;
    check("ee_err", 32'(err), 32'd1);
    check("ee_done", 32'(done), 32'd0);
    wait_idle("ee");
    check("ee_result_kept", result, 32'h40C00000);

    // N=0 completes immediately with zero
    s_start = n_start;
    start_job("n0", 5'd0);
    check("n0_done", 32'(done), 32'd1);
    check("n0_result", result, 32'd0);
    wait_idle("n0");
    check("n0_start_cnt", 32'(n_start - s_start), 32'd0);

    // reset during WAIT of element 2 of 3
    start_job("mr", 5'd3);
    serve("mre0", 32'h3FE00000, 32'h3FC00000, 32'h00000000, 32'h40280000, 0);
    serve("mre1", 32'h40000000, 32'h3F000000, 32'h40280000, 32'h0, 1);
    op_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_fma_rst", 32'(fma_rst), 32'd1);
    check("mr_req_ready", 32'(req_ready), 32'd0);
    check("mr_float_in", fma_float_in, 32'd0);
    check("mr_result", result, 32'd0);
    s_done = n_done; s_err = n_err;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mr_rel_fma_rst", 32'(fma_rst), 32'd0);
    check("mr_rel_req_ready", 32'(req_ready), 32'd1);
    check("mr_no_pulses", 32'((n_done - s_done) + (n_err - s_err)), 32'd0);

    start_job("pr", 5'd1);
    serve("pre0", 32'h3FE00000, 32'h3FC00000, 32'h00000000, 32'h40280000, 0);
    check("pr_done", 32'(done), 32'd1);
    check("pr_result", result, 32'h40280000);
    op_valid = 1'b0;
    wait_idle("pr");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not reach its summary");
    $fatal(1);
  end

endmodule

// File: doc/fma_dot_sched.md
# fma_dot_sched

Sequencer that computes a floating-point dot product by repeatedly driving the shared single-precision `fma` unit. Each request is a vector length N. The block accepts N operand pairs (a_i, b_i) and, for each pair, issues the three-beat `fma` load sequence a, b, c with c set to the running sum. It captures `float_out` as the new running sum and, after the last pair, returns the IEEE-754 result with a done pulse. It sits between the matrix-multiply row/column fetch logic and one `fma` instance.

## Interface
- `MAX_LEN`, 16: maximum vector length accepted.
- `LEN_W`, $clog2(MAX_LEN+1): width of `req_len`.
- `TIMEOUT`, 32: cycles allowed in WAIT before the block aborts.

- `clk` in 1: sole clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 1: job request.
- `req_len` in LEN_W: vector length N.
- `req_ready` out 1: block can accept a job (high only in IDLE).
- `op_valid` in 1: operand pair presented.
- `op_a`, `op_b` in 32: float_t operands.
- `op_ready` out 1: pair consumed this cycle.
- `fma_start` out 1: start pulse to `fma`.
- `fma_float_in` out 32: operand beat to `fma`.
- `fma_rst` out 1: synchronous active-high reset to `fma`.
- `fma_ready` in 1: `fma` result valid.
- `fma_error` in 1: `fma` error flag.
- `fma_float_out` in 32: `fma` result.
- `result` out 32: final dot product, held until the next job completes.
- `done` out 1: one-cycle pulse when `result` updates.
- `err` out 1: one-cycle pulse on abort.
- `busy` out 1: high in every state except IDLE.

## Operation
- All outputs are registered. Values while `rst` is low: state IDLE, `result`=0, `acc`=0, `cnt`=0, `done`=`err`=`fma_start`=`op_ready`=0, `fma_float_in`=0, `fma_rst`=1, `busy`=0, `req_ready`=0.
  - `fma_rst` clears one cycle after `rst` deasserts.
  - `req_ready` rises in that same cycle.
- `fma_float_in` is 0 in every state except the ISSUE states. The `fma` error check never fires on 0.

State machine:
- **IDLE**
  - On `req_valid && req_ready`: latch N, set `acc`=0, `cnt`=0.
  - If N==0: go to DONE with `result`=0.
  - If N>MAX_LEN: go to ERR.
  - Otherwise go to FETCH.
- **FETCH**
  - Wait for `op_valid`.
  - On `op_valid`: pulse `op_ready`, latch a and b, go to ISSUE_A.
- **ISSUE_A**: `fma_start`=1, `fma_float_in`=a.
- **ISSUE_B**: `fma_start`=0, `fma_float_in`=b.
- **ISSUE_C**: `fma_float_in`=`acc`. Clear the watchdog counter and go to WAIT.
- **WAIT**
  - On `fma_ready`: set `acc`=`fma_float_out`, `cnt`+=1.
    - If `cnt`+1==N: go to DONE.
    - Otherwise go to FETCH.
  - On `fma_error`, or watchdog reaching TIMEOUT: go to ERR.
  - If `fma_ready` and `fma_error` occur in the same cycle, `fma_error` wins.
- **DONE**: `result`=`acc`, pulse `done`, go to IDLE.
- **ERR**
  - Pulse `err`, hold `fma_rst`=1 for 2 cycles, clear `acc`.
  - `result` is unchanged.
  - Then go to IDLE.

Further rules:
- `cnt` is LEN_W bits and never wraps, because N≤MAX_LEN.
- `req_valid` outside IDLE is ignored; it is not queued.
- `op_valid` outside FETCH is not consumed.
- Asserting `rst` mid-job abandons the job immediately. There is no `done` or `err` pulse, and `fma_rst`=1 flushes the `fma`.

## Timing
- Request accepted at edge E0; FETCH is entered at E0+1.
- With an operand already valid: ISSUE_A starts 1 cycle after FETCH. The three issue beats are consecutive cycles, matching the `fma` IDLE→LOAD→MULTIPLY sampling.
- The `fma` returns `fma_ready` ~6–7 cycles after sampling start.
- The next start is issued no earlier than 2 cycles after `fma_ready`, which guarantees the `fma` is back in IDLE.
- Per element: 1 (FETCH) + 3 (issue) + `fma` latency + 1.
- `done` is asserted 1 cycle after the last `fma_ready`.
- `req_ready` rises in the cycle after `done` or after the end of ERR.

## Test plan
- N=1, a=1.75 (0x3FE00000), b=1.5 (0x3FC00000) -> ISSUE_C drives 0x00000000; `result`=0x40280000 (2.625); single `done` pulse.
- N=2, pairs (1.75,1.5),(2.0,0.5) with `op_valid` held high -> second ISSUE_C drives 0x40280000; `result`=0x40680000 (3.625); exactly 2 `op_ready` pulses.
- N=0 -> no `fma_start`; `done` 2 cycles after request, `result`=0; N=MAX_LEN+1 -> `err` pulse, `fma_rst` high 2 cycles, no `op_ready`.
- `fma_ready` never asserted -> `err` after TIMEOUT cycles in WAIT, `busy` drops, `result` keeps its previous value; a new job then completes normally.
- `fma_error` and `fma_ready` in the same cycle -> `err`, not `done`; `acc` cleared.
- `rst` low during WAIT of element 2 of 3 -> all outputs at reset values asynchronously, no `done`/`err`; a subsequent N=1 job gives the correct result.
